// File: rtl/fe_queue_pkg.sv
// Shared fetch-stage definitions: state encoding and the default jump-class
// decode constants (also used by decode so both agree on what a jump is).
package fe_pkg;

  typedef enum logic [1:0] {
    FE_RUN   = 2'd0,
    FE_JWAIT = 2'd1,
    FE_HOLD  = 2'd2
  } fe_state_e;

  // A word is jump-class when (word & FE_JMP_MASK) == FE_JMP_MATCH.
  localparam logic [15:0] FE_JMP_MASK  = 16'hF0E0;
  localparam logic [15:0] FE_JMP_MATCH = 16'h0000;

endpackage

// File: rtl/fe_queue_if.sv
// Fetch queue bus: instruction-memory side (o_req / i_rdy / i_data) and
// decode side (o_rdy / i_take / o_reg).
//
// Handshake: a memory word transfers on a cycle where o_req & i_rdy; a head
// word transfers to decode on a cycle where o_rdy & i_take (and no flush).
// i_rdy without o_req, or i_take without o_rdy, has no effect.
interface fe_queue_if #(
  parameter int WIDTH = 16
) ();
  logic             i_rdy;
  logic [WIDTH-1:0] i_data;
  logic             o_req;
  logic             i_take;
  logic             o_rdy;
  logic [WIDTH-1:0] o_reg;

  // Environment side: memory + decode.
  modport master (
    output i_rdy, i_data, i_take,
    input  o_req, o_rdy, o_reg
  );

  // Fetch queue side.
  modport slave (
    input  i_rdy, i_data, i_take,
    output o_req, o_rdy, o_reg
  );
endinterface

// File: rtl/fe_queue_fifo_core.sv
// WIDTH x DEPTH register-array FIFO with synchronous clear. DEPTH must be a
// power of two so the pointers wrap naturally. The caller guarantees no push
// when full and no pop when empty.
module fe_fifo_core #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         a_rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; clear empties the queue in one cycle.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));
endmodule

// File: rtl/fe_queue.sv
// Prefetching fetch stage: pulls words from instruction memory into a FIFO
// and hands the oldest word to decode. Fetch stops on hold, on flush, when
// full, and after a jump-class word until i_hold_clr releases it.
// Optional build macro FE_QUEUE_BYPASS_EN: a word arriving at an empty queue
// is presented to decode in the same cycle (and not stored if taken).
module fe_queue
  import fe_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] JMP_MASK  = WIDTH'(FE_JMP_MASK),
  parameter logic [WIDTH-1:0] JMP_MATCH = WIDTH'(FE_JMP_MATCH)
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic                       i_hold,
  input  logic                       i_hold_clr,
  input  logic                       i_flush,
  fe_queue_if.slave                  bus,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_jwait,
  output fe_state_e                  o_state
);
  fe_state_e        state;
  fe_state_e        state_nxt;
  logic             is_jump;
  logic             push;
  logic             pop;
  logic             fifo_push;
  logic             fifo_pop;
  logic             bypass_take;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] fifo_rdata;

  assign is_jump = ((bus.i_data & JMP_MASK) == JMP_MATCH);

  // Combinational so hold/flush abort the fetch in the same cycle; reset
  // forces it low so memory never sees a request during reset.
  assign bus.o_req = (state == FE_RUN) & ~i_hold & ~i_flush & ~full & ~a_rst;
  assign push      = bus.o_req & bus.i_rdy;

`ifdef FE_QUEUE_BYPASS_EN
  assign bus.o_rdy   = ~empty | push;
  assign bus.o_reg   = empty ? bus.i_data : fifo_rdata;
  assign bypass_take = empty & push & bus.i_take;
`else
  assign bus.o_rdy   = ~empty;
  assign bus.o_reg   = fifo_rdata;
  assign bypass_take = 1'b0;
`endif

  assign pop       = bus.o_rdy & bus.i_take & ~i_flush;
  assign fifo_push = push & ~bypass_take;
  assign fifo_pop  = pop & ~empty;

  fe_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .a_rst (a_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clr   (i_flush),
    .wdata (bus.i_data),
    .rdata (fifo_rdata),
    .count (o_count),
    .full  (full),
    .empty (empty)
  );

  // State register.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) state <= FE_RUN;
    else       state <= state_nxt;
  end

  // Next state: flush, then hold-clear, then hold, then jump detection.
  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = (i_hold & ~i_hold_clr) ? FE_HOLD : FE_RUN;
    end else if (i_hold_clr) begin
      state_nxt = FE_RUN;
    end else if (i_hold) begin
      state_nxt = FE_HOLD;
    end else if ((state == FE_RUN) && push && is_jump) begin
      state_nxt = FE_JWAIT;
    end
  end

  assign o_jwait = (state == FE_JWAIT);
  assign o_state = state;
endmodule

// File: tb/tb_fe_queue.sv
// Directed bench for fe_queue with a scoreboard of expected decode words.
module tb_fe_queue;
  import fe_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            a_rst;
  logic            i_hold;
  logic            i_hold_clr;
  logic            i_flush;
  logic [CW-1:0]   o_count;
  logic            o_jwait;
  fe_state_e       o_state;

  fe_queue_if #(.WIDTH(WIDTH)) bus ();

  fe_queue #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .JMP_MASK  (16'hF0E0),
    .JMP_MATCH (16'h0000)
  ) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .i_hold     (i_hold),
    .i_hold_clr (i_hold_clr),
    .i_flush    (i_flush),
    .bus        (bus),
    .o_count    (o_count),
    .o_jwait    (o_jwait),
    .o_state    (o_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every decode handshake pops one expected word.
  always @(negedge clk) begin
    if (!a_rst && bus.o_rdy === 1'b1 && bus.i_take === 1'b1 && !i_flush) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected no pop", bus.o_reg);
      end else begin
        check("pop_data", 32'(bus.o_reg), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] w [5];
    w[0] = 16'h1234; w[1] = 16'h2345; w[2] = 16'h3456; w[3] = 16'h4567; w[4] = 16'h5678;

    a_rst = 1'b1; i_hold = 1'b0; i_hold_clr = 1'b0; i_flush = 1'b0;
    bus.i_rdy = 1'b0; bus.i_data = '0; bus.i_take = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req",   bus.o_req, 0);
    check("rst_rdy",   bus.o_rdy, 0);
    check("rst_count", o_count, 0);
    check("rst_jwait", o_jwait, 0);
    check("rst_state", o_state, FE_RUN);
    step();
    a_rst = 1'b0;

    // Fill: four accepted, fifth refused while full
    for (int k = 0; k < 5; k++) begin
      bus.i_rdy  = 1'b1;
      bus.i_data = w[k];
      @(negedge clk);
      check("fill_req", bus.o_req, 32'(k < 4));
      if (k < 4) exp_q.push_back(w[k]);
      step();
    end
    bus.i_rdy = 1'b0;
    @(negedge clk);
    check("full_count", o_count, 4);
    check("full_req",   bus.o_req, 0);
    check("full_head",  bus.o_reg, 16'h1234);
    check("full_rdy",   bus.o_rdy, 1);

    // Drain: no fetch while full even when popping
    step();
    bus.i_take = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("pop_full_req", bus.o_req, 0);
      step();
    end
    bus.i_take = 1'b0;
    @(negedge clk);
    check("drain_rdy",   bus.o_rdy, 0);
    check("drain_req",   bus.o_req, 1);
    check("drain_count", o_count, 0);

    // Jump-class word stalls fetch until hold-clear
    step();
    bus.i_rdy  = 1'b1;
    bus.i_data = 16'h0A1F;
    exp_q.push_back(16'h0A1F);
    step();
    bus.i_data = 16'h1111;
    @(negedge clk);
    check("jw_jwait", o_jwait, 1);
    check("jw_req",   bus.o_req, 0);
    check("jw_state", o_state, FE_JWAIT);
    step();
    bus.i_rdy  = 1'b0;
    i_hold_clr = 1'b1;
    @(negedge clk);
    check("jw_count", o_count, 1);
    step();
    i_hold_clr = 1'b0;
    @(negedge clk);
    check("jw_rel_state", o_state, FE_RUN);
    check("jw_rel_req",   bus.o_req, 1);
    check("jw_rel_jwait", o_jwait, 0);
    bus.i_take = 1'b1;
    step();
    bus.i_take = 1'b0;
    @(negedge clk);
    check("jw_drain_count", o_count, 0);

    // Hold aborts fetch in the same cycle; hold-clear beats hold
    step();
    i_hold     = 1'b1;
    bus.i_rdy  = 1'b1;
    bus.i_data = 16'h2222;
    @(negedge clk);
    check("hold_req", bus.o_req, 0);
    step();
    bus.i_rdy = 1'b0;
    @(negedge clk);
    check("hold_state", o_state, FE_HOLD);
    check("hold_count", o_count, 0);
    i_hold_clr = 1'b1;
    step();
    i_hold     = 1'b0;
    i_hold_clr = 1'b0;
    @(negedge clk);
    check("holdclr_state", o_state, FE_RUN);
    check("holdclr_req",   bus.o_req, 1);

    // Flush with take and rdy high: no pop, no push, queue emptied
    step();
    bus.i_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.i_data = 16'h7001 + 16'(j);
      step();
    end
    bus.i_rdy = 1'b0;
    @(negedge clk);
    check("pre_flush_count", o_count, 3);
    step();
    i_flush    = 1'b1;
    bus.i_take = 1'b1;
    bus.i_rdy  = 1'b1;
    bus.i_data = 16'h7004;
    @(negedge clk);
    check("flush_req", bus.o_req, 0);
    step();
    i_flush    = 1'b0;
    bus.i_take = 1'b0;
    bus.i_rdy  = 1'b0;
    @(negedge clk);
    check("flush_count", o_count, 0);
    check("flush_rdy",   bus.o_rdy, 0);
    check("flush_state", o_state, FE_RUN);

    // Flush together with hold lands in HOLD
    step();
    i_flush = 1'b1;
    i_hold  = 1'b1;
    step();
    i_flush = 1'b0;
    i_hold  = 1'b0;
    @(negedge clk);
    check("flush_hold_state", o_state, FE_HOLD);
    check("flush_hold_req",   bus.o_req, 0);
    i_hold_clr = 1'b1;
    step();
    i_hold_clr = 1'b0;
    @(negedge clk);
    check("flush_hold_rel", o_state, FE_RUN);

`ifdef FE_QUEUE_BYPASS_EN
    // Empty queue: word goes straight to decode and is not stored
    step();
    bus.i_rdy  = 1'b1;
    bus.i_data = 16'hBEEF;
    bus.i_take = 1'b1;
    exp_q.push_back(16'hBEEF);
    @(negedge clk);
    check("byp_rdy", bus.o_rdy, 1);
    check("byp_reg", bus.o_reg, 16'hBEEF);
    step();
    bus.i_rdy  = 1'b0;
    bus.i_take = 1'b0;
    @(negedge clk);
    check("byp_count", o_count, 0);
`else
    // One-cycle latency from memory to decode
    step();
    bus.i_rdy  = 1'b1;
    bus.i_data = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    @(negedge clk);
    check("lat_rdy_same", bus.o_rdy, 0);
    step();
    bus.i_rdy = 1'b0;
    @(negedge clk);
    check("lat_rdy_next", bus.o_rdy, 1);
    check("lat_reg",      bus.o_reg, 16'h5A5A);
    bus.i_take = 1'b1;
    step();
    bus.i_take = 1'b0;
    @(negedge clk);
    check("lat_count", o_count, 0);
`endif

    // Reset mid-operation discards the queue
    step();
    bus.i_rdy  = 1'b1;
    bus.i_data = 16'h3131;
    step();
    step();
    bus.i_rdy = 1'b0;
    #2 a_rst = 1'b1;
    @(negedge clk);
    check("mid_rst_count", o_count, 0);
    check("mid_rst_req",   bus.o_req, 0);
    check("mid_rst_rdy",   bus.o_rdy, 0);
    step();
    a_rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", o_state, FE_RUN);
    check("post_rst_req",   bus.o_req, 1);

    // Final report
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
